imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 46 ++++
 rtl/imem_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader:
// FSM states, header layout and the per-state status flags.
package imem_loader_pkg;

    localparam int LEN_W     = 16;
    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic ready;
        logic busy;
        logic done;
        logic error;
        logic core_run;
    } status_t;

    // Status outputs are a pure function of the state being entered, so they
    // can be registered together with the state itself.
    function automatic status_t state_status(state_t s);
        status_t st;
        st = '0;
        case (s)
            LEN_LO, LEN_HI, DATA, CHECK: begin
                st.ready = 1'b1;
                st.busy  = 1'b1;
            end
            DONE: begin
                st.done     = 1'b1;
                st.core_run = 1'b1;
            end
            ERROR:   st.error = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted payload bytes little-endian into 32-bit words and pulses
// word_valid for one cycle after the fourth byte of each word.
module imem_word_assembler
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx;
    logic [23:0] partial;

    // Lets the parent see, in the same cycle, that this byte closes a word.
    assign word_last = (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            partial    <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                idx <= 2'd0;
            end else if (byte_en) begin
                unique case (idx)
                    2'd0: partial[7:0]   <= byte_in;
                    2'd1: partial[15:8]  <= byte_in;
                    2'd2: partial[23:16] <= byte_in;
                    default: begin
                        word       <= {byte_in, partial};
                        word_valid <= 1'b1;
                    end
                endcase
                idx <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length header, writes the payload
// into instruction memory word by word and validates a trailing checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = 1024
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    localparam int                LEN_HI_LSB = 8 * (HDR_BYTES - 1);
    localparam logic [LEN_W:0]    DEPTH_L    = (LEN_W + 1)'(DEPTH);

    state_t             state;
    status_t            status;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   word_idx;
    logic [7:0]         sum;
    logic               accept;
    logic               arm;
    logic               word_last;
    logic [LEN_W-1:0]   hdr_len;

    assign accept     = byte_valid && status.ready;
    assign arm        = load_start && (state == IDLE || state == DONE || state == ERROR);
    assign hdr_len    = {byte_data, len[7:0]};

    assign byte_ready = status.ready;
    assign busy       = status.busy;
    assign load_done  = status.done;
    assign load_error = status.error;
    assign core_rst_n = status.core_run;

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (arm),
        .byte_en    (accept && state == DATA),
        .byte_in    (byte_data),
        .word_last  (word_last),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    // The address is latched on the byte that completes a word, so it lines
    // up with the assembler's one-cycle-later write strobe and then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            status     <= state_status(IDLE);
            len        <= '0;
            word_idx   <= '0;
            sum        <= 8'd0;
            imem_waddr <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (load_start) begin
                        state    <= LEN_LO;
                        status   <= state_status(LEN_LO);
                        sum      <= 8'd0;
                        word_idx <= '0;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= byte_data;
                        sum      <= sum + byte_data;
                        state    <= LEN_HI;
                        status   <= state_status(LEN_HI);
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[LEN_HI_LSB +: 8] <= byte_data;
                        sum                  <= sum + byte_data;
                        if ({1'b0, hdr_len} > DEPTH_L) begin
                            state  <= ERROR;
                            status <= state_status(ERROR);
                        end else if (hdr_len == '0) begin
                            state  <= CHECK;
                            status <= state_status(CHECK);
                        end else begin
                            state  <= DATA;
                            status <= state_status(DATA);
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        sum <= sum + byte_data;
                        if (word_last) begin
                            imem_waddr <= {{(30 - LEN_W){1'b0}}, word_idx, 2'b00};
                            word_idx   <= word_idx + LEN_W'(1);
                            if (word_idx == len - LEN_W'(1)) begin
                                state  <= CHECK;
                                status <= state_status(CHECK);
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (byte_data == sum) begin
                            state  <= DONE;
                            status <= state_status(DONE);
                        end else begin
                            state  <= ERROR;
                            status <= state_status(ERROR);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    status <= state_status(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a stream-level
// model that derives writes and the final outcome from the byte sequence.
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        load_done;
    logic        load_error;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          unstable = 0;
    logic [7:0]  stream[$];
    logic [63:0] seen[$];
    logic [63:0] exp_w[$];
    logic        exp_done;
    logic        exp_err;
    int          exp_len;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_valid = 1'b0;

    // Capture every write and flag any address/data movement without a strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (imem_we)
                seen.push_back({imem_waddr, imem_wdata});
            else if (prev_valid && (imem_waddr !== prev_addr || imem_wdata !== prev_data))
                unstable++;
            prev_addr  = imem_waddr;
            prev_data  = imem_wdata;
            prev_valid = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference model: interpret the stream as header, payload words, checksum.
    task automatic buildExpect();
        int          n;
        logic [7:0]  s8;
        logic [31:0] w;
        exp_w.delete();
        n  = int'(stream[0]) + 256 * int'(stream[1]);
        s8 = stream[0] + stream[1];
        if (n > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_len  = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                w  = w | (32'(stream[2 + 4 * k + j]) << (8 * j));
                s8 = s8 + stream[2 + 4 * k + j];
            end
            exp_w.push_back({32'(4 * k), w});
        end
        exp_len  = 2 + 4 * n + 1;
        exp_done = (stream[2 + 4 * n] == s8);
        exp_err  = !exp_done;
    endtask

    task automatic applyStimulus(input int count, input int gap, input bit poke);
        int t;
        for (int i = 0; i < count; i++) begin
            t = 0;
            while (!byte_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (!byte_ready) begin
                checkOutput("ready_timeout", 32'(byte_ready), 32'd1);
                return;
            end
            byte_valid = 1'b1;
            byte_data  = stream[i];
            load_start = poke && (i == 2);
            @(posedge clk); #1;
            byte_valid = 1'b0;
            load_start = 1'b0;
            byte_data  = 8'($urandom);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic runLoad(input string name, input int gap, input bit poke);
        int m;
        buildExpect();
        seen.delete();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        checkOutput({name, "_armed_busy"}, 32'(busy), 32'd1);
        checkOutput({name, "_armed_core_rst_n"}, 32'(core_rst_n), 32'd0);
        checkOutput({name, "_armed_done"}, 32'(load_done | load_error), 32'd0);
        applyStimulus(exp_len, gap, poke);
        checkOutput({name, "_load_done"}, 32'(load_done), 32'(exp_done));
        checkOutput({name, "_load_error"}, 32'(load_error), 32'(exp_err));
        checkOutput({name, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
        checkOutput({name, "_idle_flags"}, 32'({busy, byte_ready}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, "_write_count"}, 32'(seen.size()), 32'(exp_w.size()));
        m = (seen.size() < exp_w.size()) ? seen.size() : exp_w.size();
        for (int k = 0; k < m; k++) begin
            checkOutput({name, "_waddr"}, seen[k][63:32], exp_w[k][63:32]);
            checkOutput({name, "_wdata"}, seen[k][31:0], exp_w[k][31:0]);
        end
    endtask

    initial begin
        logic [7:0] s8;
        int         n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", 32'({byte_ready, busy, load_done, load_error, core_rst_n, imem_we}), 32'd0);
        checkOutput("reset_waddr", imem_waddr, 32'd0);
        checkOutput("reset_wdata", imem_wdata, 32'd0);
        rst_n = 1'b1;

        // Bytes offered while idle must be ignored.
        byte_valid = 1'b1;
        byte_data  = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        checkOutput("idle_ignores_bytes", 32'({busy, byte_ready}), 32'd0);

        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        runLoad("nominal", 0, 1'b0);

        stream = '{8'h00, 8'h00, 8'h00};
        runLoad("empty", 0, 1'b0);

        stream = '{8'h01, 8'h04};
        runLoad("oversize", 0, 1'b0);
        checkOutput("oversize_ready_after", 32'(byte_ready), 32'd0);

        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB9};
        runLoad("bad_checksum", 0, 1'b0);

        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        runLoad("gaps", 3, 1'b1);

        // Abort a load mid-payload with reset, then reload from scratch.
        buildExpect();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        applyStimulus(6, 3, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_flags", 32'({byte_ready, busy, load_done, load_error, core_rst_n, imem_we}), 32'd0);
        checkOutput("midreset_waddr", imem_waddr, 32'd0);
        checkOutput("midreset_wdata", imem_wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h13;
        repeat (2) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        checkOutput("postreset_no_resume", 32'({busy, byte_ready, load_done}), 32'd0);
        runLoad("reload", 3, 1'b0);

        for (int r = 0; r < 6; r++) begin
            stream.delete();
            n = $urandom_range(0, 5);
            stream.push_back(8'(n));
            stream.push_back(8'h00);
            s8 = 8'(n);
            for (int b = 0; b < 4 * n; b++) begin
                stream.push_back(8'($urandom));
                s8 = s8 + stream[stream.size() - 1];
            end
            if ($urandom_range(0, 3) == 0)
                s8 = s8 + 8'd1;
            stream.push_back(s8);
            runLoad($sformatf("rand%0d", r), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        checkOutput("write_bus_stable", 32'(unstable), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
